// File: rtl/hazard_unit_mc_pkg.sv
// Shared encodings for the multi-cycle hazard unit: forward selects and PCSrc values.
package hazard_unit_mc_pkg;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  typedef enum logic [1:0] {
    PC_SEQ    = 2'b00,
    PC_BRANCH = 2'b01,
    PC_JUMP   = 2'b10,
    PC_JALR   = 2'b11
  } pcsrc_e;

  // The M stage holds the younger result, so it takes precedence over W.
  function automatic logic [1:0] fwd_pick(input logic hit_m, input logic hit_w);
    if (hit_m) begin
      return FWD_M;
    end else if (hit_w) begin
      return FWD_W;
    end else begin
      return FWD_RF;
    end
  endfunction

endpackage

// File: rtl/hazard_mc_counter.sv
// Busy counter for the multi-cycle execute unit; drives McBusy and the E-stage hold request.
module hazard_mc_counter #(
  parameter int MC_LAT = 4,
  parameter int CNT_W  = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic mc_start,
  input  logic mem_wait,
  output logic mc_busy,
  output logic mc_hold
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MC_LAT - 1);

  logic [CNT_W-1:0] cnt;
  // done marks an op that finished while memory held E, so the still-asserted
  // McStartE is not mistaken for a new op once the memory wait clears.
  logic             done;

  // Count down the op latency and track completion under a memory stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= CNT_ZERO;
      done <= 1'b0;
    end else begin
      if (cnt != CNT_ZERO) begin
        cnt <= cnt - CNT_ONE;
      end else if (mc_start && !done) begin
        cnt <= CNT_LOAD;
      end else begin
        cnt <= cnt;
      end

      if ((cnt == CNT_ONE) && mem_wait) begin
        done <= 1'b1;
      end else if (!mem_wait) begin
        done <= 1'b0;
      end else begin
        done <= done;
      end
    end
  end

  assign mc_busy = (cnt != CNT_ZERO);
  assign mc_hold = (mc_start && (cnt == CNT_ZERO) && !done) || (cnt > CNT_ONE);

endmodule

// File: rtl/hazard_unit_mc.sv
// Five-stage hazard unit with multi-cycle execute, variable-latency memory and deferred branch flush.
// Optional performance counters are enabled with the HAZARD_PERF_EN macro.
module hazard_unit_mc
  import hazard_unit_mc_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int MC_LAT = 4,
  parameter int CNT_W  = 3,
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] Rs1D,
  input  logic [REG_AW-1:0] Rs2D,
  input  logic [REG_AW-1:0] Rs1E,
  input  logic [REG_AW-1:0] Rs2E,
  input  logic [REG_AW-1:0] RdE,
  input  logic [REG_AW-1:0] RdM,
  input  logic [REG_AW-1:0] RdW,
  input  logic              LoadE,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic [1:0]        PCSrcE,
  input  logic              McStartE,
  input  logic              MemReqM,
  input  logic              MemReadyM,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              StallM,
  output logic              FlushD,
  output logic              FlushE,
  output logic              FlushW,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
`ifdef HAZARD_PERF_EN
  output logic [PERF_W-1:0] PerfStallCnt,
  output logic [PERF_W-1:0] PerfFlushCnt,
`endif
  output logic              McBusy
);

  localparam logic [REG_AW-1:0] REG_ZERO = {REG_AW{1'b0}};

  logic mem_wait;
  logic lw_stall;
  logic mc_hold;
  logic branch;

  hazard_mc_counter #(
    .MC_LAT (MC_LAT),
    .CNT_W  (CNT_W)
  ) u_mc_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .mc_start (McStartE),
    .mem_wait (mem_wait),
    .mc_busy  (McBusy),
    .mc_hold  (mc_hold)
  );

  // Operand forwarding from M or W into the E-stage sources.
  always_comb begin
    ForwardAE = fwd_pick(RegWriteM && (Rs1E == RdM) && (Rs1E != REG_ZERO),
                         RegWriteW && (Rs1E == RdW) && (Rs1E != REG_ZERO));
    ForwardBE = fwd_pick(RegWriteM && (Rs2E == RdM) && (Rs2E != REG_ZERO),
                         RegWriteW && (Rs2E == RdW) && (Rs2E != REG_ZERO));
  end

  assign mem_wait = MemReqM && !MemReadyM;
  assign lw_stall = LoadE && (RdE != REG_ZERO) && ((Rs1D == RdE) || (Rs2D == RdE));
  assign branch   = (PCSrcE != PC_SEQ);

  // Stall priority memory > multi-cycle > load-use; branch flush only when E moves.
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushW = 1'b0;
    if (mem_wait) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
    end else if (mc_hold) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
    end else if (lw_stall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end else begin
      StallF = 1'b0;
    end
    // A held E keeps PCSrcE alive, so the redirect simply waits for E to move.
    if (branch && !StallE) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else begin
      FlushD = FlushD;
    end
  end

`ifdef HAZARD_PERF_EN
  // Saturating counts of fetch-stall and decode-flush cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      PerfStallCnt <= {PERF_W{1'b0}};
      PerfFlushCnt <= {PERF_W{1'b0}};
    end else begin
      if (StallF && (PerfStallCnt != {PERF_W{1'b1}})) begin
        PerfStallCnt <= PerfStallCnt + PERF_W'(1);
      end else begin
        PerfStallCnt <= PerfStallCnt;
      end
      if (FlushD && (PerfFlushCnt != {PERF_W{1'b1}})) begin
        PerfFlushCnt <= PerfFlushCnt + PERF_W'(1);
      end else begin
        PerfFlushCnt <= PerfFlushCnt;
      end
    end
  end
`endif

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Directed self-checking bench for hazard_unit_mc with hand-computed expectations.
module tb_hazard_unit_mc;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic       LoadE, RegWriteM, RegWriteW;
  logic [1:0] PCSrcE;
  logic       McStartE, MemReqM, MemReadyM;
  logic       StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
  logic [1:0] ForwardAE, ForwardBE;
  logic       McBusy;
`ifdef HAZARD_PERF_EN
  logic [31:0] PerfStallCnt, PerfFlushCnt;
`endif
  logic [6:0] ctl;

  int n_asserts = 0;
  int n_fail    = 0;

  hazard_unit_mc dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .Rs1D      (Rs1D),
    .Rs2D      (Rs2D),
    .Rs1E      (Rs1E),
    .Rs2E      (Rs2E),
    .RdE       (RdE),
    .RdM       (RdM),
    .RdW       (RdW),
    .LoadE     (LoadE),
    .RegWriteM (RegWriteM),
    .RegWriteW (RegWriteW),
    .PCSrcE    (PCSrcE),
    .McStartE  (McStartE),
    .MemReqM   (MemReqM),
    .MemReadyM (MemReadyM),
    .StallF    (StallF),
    .StallD    (StallD),
    .StallE    (StallE),
    .StallM    (StallM),
    .FlushD    (FlushD),
    .FlushE    (FlushE),
    .FlushW    (FlushW),
    .ForwardAE (ForwardAE),
    .ForwardBE (ForwardBE),
`ifdef HAZARD_PERF_EN
    .PerfStallCnt (PerfStallCnt),
    .PerfFlushCnt (PerfFlushCnt),
`endif
    .McBusy    (McBusy)
  );

  always #5 clk = ~clk;

  // {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}
  assign ctl = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW};

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    Rs1D = 5'd0; Rs2D = 5'd0; Rs1E = 5'd0; Rs2E = 5'd0;
    RdE = 5'd0; RdM = 5'd0; RdW = 5'd0;
    LoadE = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0;
    PCSrcE = 2'b00; McStartE = 1'b0; MemReqM = 1'b0; MemReadyM = 1'b0;
    #12;
    chk("reset_busy", {7'd0, McBusy}, 8'h00);
    chk("reset_ctl", {1'b0, ctl}, 8'h00);
    chk("reset_fwdA", {6'd0, ForwardAE}, 8'h00);
    rst_n = 1'b1;
    tick();

    // Forwarding
    Rs1E = 5'd5; Rs2E = 5'd5; RdM = 5'd5; RegWriteM = 1'b1; RdW = 5'd5; RegWriteW = 1'b1;
    #2;
    chk("fwdA_m_wins", {6'd0, ForwardAE}, 8'h02);
    chk("fwdB_m_wins", {6'd0, ForwardBE}, 8'h02);
    RegWriteM = 1'b0;
    #2;
    chk("fwdA_from_w", {6'd0, ForwardAE}, 8'h01);
    Rs1E = 5'd0; RdM = 5'd0; RegWriteM = 1'b1; RdW = 5'd0;
    #2;
    chk("fwdA_x0", {6'd0, ForwardAE}, 8'h00);
    Rs2E = 5'd9; RdW = 5'd9; RdM = 5'd3;
    #2;
    chk("fwdB_from_w", {6'd0, ForwardBE}, 8'h01);
    RegWriteM = 1'b0; RegWriteW = 1'b0; Rs2E = 5'd0; RdM = 5'd0; RdW = 5'd0;
    tick();

    // Load-use
    LoadE = 1'b1; RdE = 5'd7; Rs2D = 5'd7;
    #2;
    chk("lwstall", {1'b0, ctl}, 8'h62);
    RdE = 5'd0; Rs2D = 5'd0;
    #2;
    chk("lwstall_x0", {1'b0, ctl}, 8'h00);
    LoadE = 1'b0; RdE = 5'd7; Rs1D = 5'd7;
    #2;
    chk("no_load_no_stall", {1'b0, ctl}, 8'h00);
    RdE = 5'd0; Rs1D = 5'd0;
    tick();

    // Multi-cycle op, MC_LAT = 4
    McStartE = 1'b1;
    #2;
    chk("mc_t0_ctl", {1'b0, ctl}, 8'h70);
    chk("mc_t0_busy", {7'd0, McBusy}, 8'h00);
    tick(); #2;
    chk("mc_t1_ctl", {1'b0, ctl}, 8'h70);
    chk("mc_t1_busy", {7'd0, McBusy}, 8'h01);
    tick(); #2;
    chk("mc_t2_ctl", {1'b0, ctl}, 8'h70);
    chk("mc_t2_busy", {7'd0, McBusy}, 8'h01);
    tick(); #2;
    chk("mc_t3_ctl", {1'b0, ctl}, 8'h00);
    chk("mc_t3_busy", {7'd0, McBusy}, 8'h01);
    tick();
    McStartE = 1'b0;
    #2;
    chk("mc_t4_busy", {7'd0, McBusy}, 8'h00);
    chk("mc_t4_ctl", {1'b0, ctl}, 8'h00);
    tick();

    // Memory wait for 3 cycles
    MemReqM = 1'b1; MemReadyM = 1'b0;
    #2;
    chk("memwait_c0", {1'b0, ctl}, 8'h79);
    tick(); #2;
    chk("memwait_c1", {1'b0, ctl}, 8'h79);
    tick(); #2;
    chk("memwait_c2", {1'b0, ctl}, 8'h79);
    tick();
    MemReadyM = 1'b1;
    #2;
    chk("memwait_done", {1'b0, ctl}, 8'h00);
    tick();
    MemReqM = 1'b0; MemReadyM = 1'b0;

    // Deferred branch under memory wait
    MemReqM = 1'b1; PCSrcE = 2'b01;
    #2;
    chk("br_defer_c0", {1'b0, ctl}, 8'h79);
    tick(); #2;
    chk("br_defer_c1", {1'b0, ctl}, 8'h79);
    MemReadyM = 1'b1;
    #2;
    chk("br_fire", {1'b0, ctl}, 8'h06);
    tick();
    PCSrcE = 2'b00; MemReqM = 1'b0; MemReadyM = 1'b0;
    #2;
    chk("br_after", {1'b0, ctl}, 8'h00);

    // Branch together with load-use
    PCSrcE = 2'b10; LoadE = 1'b1; RdE = 5'd7; Rs1D = 5'd7;
    #2;
    chk("br_lwstall", {1'b0, ctl}, 8'h66);
    PCSrcE = 2'b00; LoadE = 1'b0; RdE = 5'd0; Rs1D = 5'd0;
    tick();

    // Multi-cycle op completing while memory holds E
    McStartE = 1'b1;
    tick();
    tick();
    MemReqM = 1'b1; MemReadyM = 1'b0;
    #2;
    chk("mcmem_cnt2", {1'b0, ctl}, 8'h79);
    tick(); #2;
    chk("mcmem_cnt1_ctl", {1'b0, ctl}, 8'h79);
    chk("mcmem_cnt1_busy", {7'd0, McBusy}, 8'h01);
    tick(); #2;
    chk("mcmem_cnt0_busy", {7'd0, McBusy}, 8'h00);
    chk("mcmem_cnt0_ctl", {1'b0, ctl}, 8'h79);
    MemReadyM = 1'b1;
    #2;
    chk("mcmem_release", {1'b0, ctl}, 8'h00);
    tick();
    McStartE = 1'b0; MemReqM = 1'b0; MemReadyM = 1'b0;
    #2;
    chk("mcmem_no_restart", {7'd0, McBusy}, 8'h00);
    tick();

    // Asynchronous reset mid-operation
    McStartE = 1'b1;
    tick();
    tick();
    #2;
    chk("rst_pre_busy", {7'd0, McBusy}, 8'h01);
    rst_n = 1'b0; McStartE = 1'b0;
    #1;
    chk("rst_async_busy", {7'd0, McBusy}, 8'h00);
    chk("rst_async_ctl", {1'b0, ctl}, 8'h00);
    tick();
    chk("rst_held_busy", {7'd0, McBusy}, 8'h00);
    rst_n = 1'b1;
    tick(); #2;
    chk("rst_after_busy", {7'd0, McBusy}, 8'h00);
    chk("rst_after_ctl", {1'b0, ctl}, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
